grey_counter: RTL and testbench
===============================

# grey_counter

Twelve-digit decimal event counter, each digit held as a 5-bit Johnson (Gray-like, one bit changes per step) code. Counts i_clk edges while enabled, loads an arbitrary 60-bit preset, and exposes one selected digit on an 8-bit output. It is the core behind the dwisehart_top pin wrapper, which maps io_in to {i_sel[5:0], reset, clock} and drives io_out from o_cnt.

## Interface
- No parameters; digit count (12) and digit width (5) are fixed.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_sel  in  8  control: [3:0] digit index, [4] output format, [5] count enable, [6] preset load, [7:6] unused in the pin wrapper (tied 0 there).
- init  in  60  preset; digit k uses init[5k+4:5k], k=0 is ones.
- ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM, bil, tenB, hunB  out  5 each  registered Johnson code of digits 0..11.
- o_cnt  out  8  selected-digit view, combinational from state and i_sel.

## Operation
- Johnson code per digit value 0..9: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
- Increment: next = {q[3:0], ~q[4]}; 10000 (9) wraps to 00000 and raises the digit's carry-out.
- Digit k increments when enable is high and digits 0..k-1 all equal 10000 (ripple-carry, evaluated on current state in the same cycle).
- Full rollover: all twelve digits at 9 -> all zero on next enabled edge.
- Load (i_sel[6]=1): all digits take init fields on the edge; load beats count.
- Any 5-bit field not among the ten legal codes, whether loaded or present in state, becomes 00000 on the next edge.
- o_cnt:
  - i_sel[3:0] in 0..11 selects digit; 12..15 -> o_cnt = 8'h00.
  - i_sel[4]=1: o_cnt = {3'b000, code}.
  - i_sel[4]=0: o_cnt[6:0] = active-high 7-segment of decoded value, a=bit0..g=bit6: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F; illegal code -> 00.
  - o_cnt[7] = 1 when all twelve digits equal 9 (terminal count), any format, valid index.

## Timing
- Reset asserted: all digits 00000 immediately; o_cnt follows combinationally (format 0, index valid -> 8'h3F; format 1 -> 8'h00).
- Reset release: counting resumes on first rising edge with i_rst_n high.
- Reset mid-count or mid-load discards the operation; no partial load.
- Count latency: one edge per increment; no pipeline; o_cnt reflects the new state in the same cycle.
- enable=0 and load=0: state holds.
- Load and enable together: loaded value appears, not incremented.
- i_sel changes affect o_cnt combinationally, never state except bits [5] and [6] at the edge.

## Structure
- Shared package: digit count, Johnson code constants J0..J9, 7-segment constants, function code->value (illegal -> invalid flag).
- Sub-module johnson_digit: 5-bit register, inputs carry_in/load/load_val, outputs q and carry_out (q==J9 & carry_in); instantiated 12 times, chained.
- Top: carry chain, terminal-count AND, output mux and segment decoder.

## Test plan
- Reset low -> all digit outputs 00000; i_sel=8'h00 -> o_cnt=8'h3F; release, enable, 10 edges -> ones=00000, tens=00001.
- Load init with all digits J9 (10000 each), i_sel=8'h40, one edge -> o_cnt[7]=1; then i_sel=8'h20, one edge -> all digits 00000, o_cnt[7]=0.
- Load digits 0..2 = 9,9,4 (ones=10000, tens=10000, hund=01111), enable one edge -> ones=0, tens=0, hund=11111, thou unchanged.
- i_sel format 1, index 2, hund=11100 -> o_cnt=8'h1C; format 0 same digit -> 8'h07; index 13 -> 8'h00.
- Load init with ones=01010 (illegal), one edge -> ones=00000; load+enable same edge with ones preset J3 -> ones=00111, not 01111.
- Assert i_rst_n low asynchronously between edges during counting -> digits clear without a clock edge; hold enable=0 -> state stays constant over 20 edges.

Source files
------------

// File: rtl/grey_counter_pkg.sv
// rtl/grey_counter_pkg.sv - shared constants and helpers for the Johnson-coded decimal counter
package grey_counter_pkg;

  localparam int NUM_DIGITS = 12;
  localparam int DIGIT_W    = 5;

  localparam logic [4:0] J0 = 5'b00000;
  localparam logic [4:0] J1 = 5'b00001;
  localparam logic [4:0] J2 = 5'b00011;
  localparam logic [4:0] J3 = 5'b00111;
  localparam logic [4:0] J4 = 5'b01111;
  localparam logic [4:0] J5 = 5'b11111;
  localparam logic [4:0] J6 = 5'b11110;
  localparam logic [4:0] J7 = 5'b11100;
  localparam logic [4:0] J8 = 5'b11000;
  localparam logic [4:0] J9 = 5'b10000;

  // active-high segments, a = bit 0 .. g = bit 6
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_val_t;

  function automatic digit_val_t decode_digit(input logic [4:0] code);
    digit_val_t r;
    r.valid = 1'b1;
    r.value = 4'd0;
    case (code)
      J0: r.value = 4'd0;
      J1: r.value = 4'd1;
      J2: r.value = 4'd2;
      J3: r.value = 4'd3;
      J4: r.value = 4'd4;
      J5: r.value = 4'd5;
      J6: r.value = 4'd6;
      J7: r.value = 4'd7;
      J8: r.value = 4'd8;
      J9: r.value = 4'd9;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] value);
    logic [6:0] s;
    case (value)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/grey_counter_johnson_digit.sv
// rtl/grey_counter_johnson_digit.sv - one Johnson-coded decimal digit with load and ripple carry
module johnson_digit
  import grey_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carry_in,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic [4:0] q,
  output logic       carry_out
);

  logic q_legal;
  logic load_legal;

  assign q_legal    = decode_digit(q).valid;
  assign load_legal = decode_digit(load_val).valid;
  assign carry_out  = carry_in & (q == J9);

  // illegal codes, loaded or resident, are scrubbed to zero on the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= J0;
    end else if (load) begin
      q <= load_legal ? load_val : J0;
    end else if (!q_legal) begin
      q <= J0;
    end else if (carry_in) begin
      q <= {q[3:0], ~q[4]};
    end
  end

endmodule

// File: rtl/grey_counter.sv
// rtl/grey_counter.sv - twelve-digit Johnson-coded decimal counter with selectable digit view
module grey_counter
  import grey_counter_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_sel,
  input  logic [59:0] init,
  output logic [4:0]  ones,
  output logic [4:0]  tens,
  output logic [4:0]  hund,
  output logic [4:0]  thou,
  output logic [4:0]  tenT,
  output logic [4:0]  hunT,
  output logic [4:0]  mil,
  output logic [4:0]  tenM,
  output logic [4:0]  hunM,
  output logic [4:0]  bil,
  output logic [4:0]  tenB,
  output logic [4:0]  hunB,
  output logic [7:0]  o_cnt
);

  logic [4:0]          digit_q [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;
  logic                terminal;
  logic                unused_sel;

  assign unused_sel = i_sel[7];
  assign carry[0]   = i_sel[5];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    johnson_digit u_digit (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .carry_in  (carry[k]),
      .load      (i_sel[6]),
      .load_val  (init[DIGIT_W*k +: DIGIT_W]),
      .q         (digit_q[k]),
      .carry_out (carry[k+1])
    );
  end

  assign ones = digit_q[0];
  assign tens = digit_q[1];
  assign hund = digit_q[2];
  assign thou = digit_q[3];
  assign tenT = digit_q[4];
  assign hunT = digit_q[5];
  assign mil  = digit_q[6];
  assign tenM = digit_q[7];
  assign hunM = digit_q[8];
  assign bil  = digit_q[9];
  assign tenB = digit_q[10];
  assign hunB = digit_q[11];

  always_comb begin
    terminal = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q[k] != J9) terminal = 1'b0;
    end
  end

  // indices 12..15 leave sel_valid low and force the whole view to zero
  logic       sel_valid;
  logic [4:0] sel_code;
  digit_val_t sel_dec;

  always_comb begin
    sel_valid = 1'b0;
    sel_code  = J0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (i_sel[3:0] == 4'(k)) begin
        sel_valid = 1'b1;
        sel_code  = digit_q[k];
      end
    end
    sel_dec = decode_digit(sel_code);
  end

  always_comb begin
    o_cnt = 8'h00;
    if (sel_valid) begin
      if (i_sel[4]) begin
        o_cnt = {terminal, 2'b00, sel_code};
      end else begin
        o_cnt = {terminal, sel_dec.valid ? seg_of(sel_dec.value) : 7'h00};
      end
    end
  end

endmodule

// File: tb/tb_grey_counter.sv
// tb/tb_grey_counter.sv - directed self-checking bench for grey_counter
module tb_grey_counter;

  localparam logic [4:0] J0 = 5'b00000;
  localparam logic [4:0] J1 = 5'b00001;
  localparam logic [4:0] J2 = 5'b00011;
  localparam logic [4:0] J3 = 5'b00111;
  localparam logic [4:0] J4 = 5'b01111;
  localparam logic [4:0] J5 = 5'b11111;
  localparam logic [4:0] J6 = 5'b11110;
  localparam logic [4:0] J7 = 5'b11100;
  localparam logic [4:0] J9 = 5'b10000;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_sel;
  logic [59:0] init;
  logic [4:0]  ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM, bil, tenB, hunB;
  logic [7:0]  o_cnt;

  int n_cmp = 0;
  int n_err = 0;

  grey_counter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sel   (i_sel),
    .init    (init),
    .ones    (ones),
    .tens    (tens),
    .hund    (hund),
    .thou    (thou),
    .tenT    (tenT),
    .hunT    (hunT),
    .mil     (mil),
    .tenM    (tenM),
    .hunM    (hunM),
    .bil     (bil),
    .tenB    (tenB),
    .hunB    (hunB),
    .o_cnt   (o_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [59:0] all_digits();
    return {hunB, tenB, bil, hunM, tenM, mil, hunT, tenT, thou, hund, tens, ones};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_sel   = 8'h00;
    init    = '0;
    #2;
    n_cmp++;
    if (all_digits() !== 60'd0) begin
      n_err++;
      $display("FAIL reset_digits: got %h expected %h", all_digits(), 60'd0);
    end
    n_cmp++;
    if (o_cnt !== 8'h3F) begin
      n_err++;
      $display("FAIL reset_ocnt_fmt0: got %h expected %h", o_cnt, 8'h3F);
    end
    i_sel = 8'h10;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ocnt_fmt1: got %h expected %h", o_cnt, 8'h00);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_sel   = 8'h00;
  endtask

  task automatic test_count();
    i_sel = 8'h20;
    for (int i = 0; i < 9; i++) tick();
    i_sel = 8'h00;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h6F) begin
      n_err++;
      $display("FAIL count9_seg: got %h expected %h", o_cnt, 8'h6F);
    end
    i_sel = 8'h20;
    tick();
    i_sel = 8'h00;
    n_cmp++;
    if (ones !== J0 || tens !== J1) begin
      n_err++;
      $display("FAIL count10: got ones=%b tens=%b expected ones=%b tens=%b", ones, tens, J0, J1);
    end
    i_sel = 8'h01;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h06) begin
      n_err++;
      $display("FAIL count10_tens_seg: got %h expected %h", o_cnt, 8'h06);
    end
  endtask

  task automatic test_rollover();
    init  = {12{J9}};
    i_sel = 8'h40;
    tick();
    n_cmp++;
    if (o_cnt !== 8'hEF) begin
      n_err++;
      $display("FAIL terminal_view: got %h expected %h", o_cnt, 8'hEF);
    end
    i_sel = 8'h1B;
    #1;
    n_cmp++;
    if (o_cnt !== {3'b100, J9}) begin
      n_err++;
      $display("FAIL terminal_fmt1_idx11: got %h expected %h", o_cnt, {3'b100, J9});
    end
    i_sel = 8'h20;
    tick();
    n_cmp++;
    if (all_digits() !== 60'd0) begin
      n_err++;
      $display("FAIL rollover_digits: got %h expected %h", all_digits(), 60'd0);
    end
    i_sel = 8'h00;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h3F) begin
      n_err++;
      $display("FAIL rollover_view: got %h expected %h", o_cnt, 8'h3F);
    end
  endtask

  task automatic test_carry();
    init  = {40'd0, J2, J4, J9, J9};
    i_sel = 8'h40;
    tick();
    i_sel = 8'h20;
    tick();
    i_sel = 8'h00;
    n_cmp++;
    if (all_digits() !== {40'd0, J2, J5, J0, J0}) begin
      n_err++;
      $display("FAIL ripple_carry: got %h expected %h", all_digits(), {40'd0, J2, J5, J0, J0});
    end
  endtask

  task automatic test_output_mux();
    init  = {45'd0, J7, J0, J0};
    i_sel = 8'h40;
    tick();
    i_sel = 8'h12;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h1C) begin
      n_err++;
      $display("FAIL mux_fmt1_idx2: got %h expected %h", o_cnt, 8'h1C);
    end
    i_sel = 8'h02;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h07) begin
      n_err++;
      $display("FAIL mux_fmt0_idx2: got %h expected %h", o_cnt, 8'h07);
    end
    i_sel = 8'h0D;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL mux_idx13: got %h expected %h", o_cnt, 8'h00);
    end
    i_sel = 8'h1C;
    #1;
    n_cmp++;
    if (o_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL mux_idx12_fmt1: got %h expected %h", o_cnt, 8'h00);
    end
  endtask

  task automatic test_illegal();
    init  = {50'd0, 5'b10101, 5'b01010};
    i_sel = 8'h40;
    tick();
    i_sel = 8'h00;
    n_cmp++;
    if (ones !== J0 || tens !== J0) begin
      n_err++;
      $display("FAIL illegal_load: got ones=%b tens=%b expected %b", ones, tens, J0);
    end
  endtask

  task automatic test_load_priority();
    init  = {55'd0, J3};
    i_sel = 8'h60;
    tick();
    i_sel = 8'h00;
    n_cmp++;
    if (ones !== J3) begin
      n_err++;
      $display("FAIL load_beats_count: got %b expected %b", ones, J3);
    end
  endtask

  task automatic test_async_reset();
    init  = {12{J5}};
    i_sel = 8'h40;
    tick();
    i_sel = 8'h20;
    tick();
    n_cmp++;
    if (ones !== J6) begin
      n_err++;
      $display("FAIL pre_reset_count: got %b expected %b", ones, J6);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_digits() !== 60'd0) begin
      n_err++;
      $display("FAIL async_reset_digits: got %h expected %h", all_digits(), 60'd0);
    end
    n_cmp++;
    if (o_cnt !== 8'h3F) begin
      n_err++;
      $display("FAIL async_reset_view: got %h expected %h", o_cnt, 8'h3F);
    end
    i_sel = 8'h40;
    tick();
    n_cmp++;
    if (all_digits() !== 60'd0) begin
      n_err++;
      $display("FAIL reset_blocks_load: got %h expected %h", all_digits(), 60'd0);
    end
    @(negedge i_clk);
    i_sel   = 8'h00;
    i_rst_n = 1'b1;
    tick();
    n_cmp++;
    if (all_digits() !== 60'd0) begin
      n_err++;
      $display("FAIL post_reset_hold: got %h expected %h", all_digits(), 60'd0);
    end
  endtask

  task automatic test_hold();
    init  = {J1, J2, J3, J4, J5, J6, J7, J9, J0, J1, J2, J3};
    i_sel = 8'h40;
    tick();
    i_sel = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (all_digits() !== {J1, J2, J3, J4, J5, J6, J7, J9, J0, J1, J2, J3}) begin
        n_err++;
        $display("FAIL hold_edge%0d: got %h expected %h", i, all_digits(),
                 {J1, J2, J3, J4, J5, J6, J7, J9, J0, J1, J2, J3});
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_carry();
    test_output_mux();
    test_illegal();
    test_load_priority();
    test_async_reset();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
